// File: rtl/serial_word_framer.sv
// Parallel-to-serial framer: buffers words in a 2-entry FIFO and sends each one MSB-first,
// followed by a one-cycle load strobe for the downstream deserializer.
module serial_word_framer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             serial_out,
    output logic             load_out,
    output logic             busy,
    output logic [CNT_W-1:0] words_sent
);

    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LOAD
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   fifoMem_q [2];
    logic               wrPtr_q, rdPtr_q;
    logic [1:0]         count_q;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic [BIT_W-1:0]   bitCnt_q, bitCnt_d;
    logic               serial_q, serial_d;
    logic               load_q, load_d;
    logic [CNT_W-1:0]   sent_q, sent_d;
    logic               push, pop;
    logic [WIDTH-1:0]   head;

    assign in_ready   = (count_q != 2'd2);
    assign push       = in_valid && in_ready;
    assign head       = fifoMem_q[rdPtr_q];
    assign serial_out = serial_q;
    assign load_out   = load_q;
    assign words_sent = sent_q;
    assign busy       = (state_q != IDLE) || (count_q != 2'd0);

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        bitCnt_d = bitCnt_q;
        serial_d = 1'b0;
        load_d   = 1'b0;
        sent_d   = sent_q;
        pop      = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != 2'd0) begin
                    pop      = 1'b1;
                    sr_d     = head;
                    serial_d = head[WIDTH-1];
                    bitCnt_d = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (bitCnt_q == BIT_W'(WIDTH - 1)) begin
                    load_d  = 1'b1;
                    state_d = LOAD;
                end else begin
                    sr_d     = sr_q << 1;
                    serial_d = sr_q[WIDTH-2];
                    bitCnt_d = bitCnt_q + 1'b1;
                end
            end
            LOAD: begin
                // A waiting word starts immediately so frames stream with no idle gap.
                sent_d = sent_q + CNT_W'(1);
                if (count_q != 2'd0) begin
                    pop      = 1'b1;
                    sr_d     = head;
                    serial_d = head[WIDTH-1];
                    bitCnt_d = '0;
                    state_d  = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            sr_q     <= '0;
            bitCnt_q <= '0;
            serial_q <= 1'b0;
            load_q   <= 1'b0;
            sent_q   <= '0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            bitCnt_q <= bitCnt_d;
            serial_q <= serial_d;
            load_q   <= load_d;
            sent_q   <= sent_d;
        end
    end

    // Simultaneous push and pop leaves the occupancy unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) fifoMem_q[i] <= '0;
            wrPtr_q <= 1'b0;
            rdPtr_q <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (push) begin
                fifoMem_q[wrPtr_q] <= in_data;
                wrPtr_q            <= ~wrPtr_q;
            end
            if (pop) begin
                rdPtr_q <= ~rdPtr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_word_framer.sv
// Bench for serial_word_framer: a queue-based frame model plus a behavioural deserializer,
// checked every cycle, with directed scenarios pinned by hand-computed values.
module tb_serial_word_framer;

    localparam int WIDTH = 32;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready, serial_out, load_out, busy;
    logic [CNT_W-1:0] words_sent;
    logic             ready1, serial1, load1, busy1;
    logic [0:0]       words_sent1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_word_framer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .serial_out(serial_out), .load_out(load_out),
        .busy(busy), .words_sent(words_sent)
    );

    // Narrow counter copy fed the same stream so the wrap shows up after two frames.
    serial_word_framer #(.WIDTH(WIDTH), .CNT_W(1)) dutWrap (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(ready1), .serial_out(serial1), .load_out(load1),
        .busy(busy1), .words_sent(words_sent1)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Frame-level model: a word queue and the position within the current frame.
    logic [WIDTH-1:0] mFifo[$];
    logic [WIDTH-1:0] mFrames[$];
    logic [WIDTH-1:0] mWord = '0;
    logic             mActive = 1'b0;
    int               mPhase = 0;
    int               mSent = 0;
    logic             mPush;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mFifo.delete();
            mFrames.delete();
            mActive = 1'b0;
            mPhase  = 0;
            mWord   = '0;
            mSent   = 0;
        end else begin
            mPush = in_valid && (mFifo.size() < 2);
            if (!mActive || mPhase == WIDTH) begin
                if (mActive) mSent++;
                if (mFifo.size() > 0) begin
                    mWord   = mFifo.pop_front();
                    mActive = 1'b1;
                    mPhase  = 0;
                    mFrames.push_back(mWord);
                end else begin
                    mActive = 1'b0;
                    mPhase  = 0;
                end
            end else begin
                mPhase++;
            end
            if (mPush) mFifo.push_back(in_data);
        end
    end

    int cycleCnt = 0;
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    logic [WIDTH-1:0] desShift = '0;
    logic [WIDTH-1:0] captured[$];
    int               loadCycles[$];
    logic [WIDTH-1:0] expFrame;
    logic             eSer, eLoad, eBusy, eReady;

    always @(negedge clk) begin
        eSer   = (mActive && mPhase < WIDTH) ? mWord[WIDTH-1-mPhase] : 1'b0;
        eLoad  = mActive && (mPhase == WIDTH);
        eBusy  = mActive || (mFifo.size() > 0);
        eReady = (mFifo.size() < 2);
        checkOutput("serial_out", 64'(serial_out), 64'(eSer));
        checkOutput("load_out", 64'(load_out), 64'(eLoad));
        checkOutput("busy", 64'(busy), 64'(eBusy));
        checkOutput("in_ready", 64'(in_ready), 64'(eReady));
        checkOutput("words_sent", 64'(words_sent), 64'(mSent % 65536));
        checkOutput("wrap_words_sent", 64'(words_sent1), 64'(mSent % 2));
        checkOutput("wrap_serial", 64'(serial1), 64'(eSer));
        checkOutput("wrap_load", 64'(load1), 64'(eLoad));
        checkOutput("wrap_busy", 64'(busy1), 64'(eBusy));
        checkOutput("wrap_ready", 64'(ready1), 64'(eReady));
        if (load_out) begin
            captured.push_back(desShift);
            loadCycles.push_back(cycleCnt);
            if (mFrames.size() > 0) begin
                expFrame = mFrames.pop_front();
                checkOutput("deser_word", 64'(desShift), 64'(expFrame));
            end else begin
                checkOutput("deser_unexpected_load", 64'(1), 64'(0));
            end
        end else begin
            desShift = {desShift[WIDTH-2:0], serial_out};
        end
    end

    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #2;
    endtask

    task automatic idleCycles(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    logic [WIDTH-1:0] tw;
    logic [WIDTH-1:0] burst [4];
    logic             acc;
    int               stall, waited, capBefore;

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        #1;
        checkOutput("rst_serial", 64'(serial_out), 64'(0));
        checkOutput("rst_load", 64'(load_out), 64'(0));
        checkOutput("rst_words", 64'(words_sent), 64'(0));
        checkOutput("rst_busy", 64'(busy), 64'(0));
        checkOutput("rst_ready", 64'(in_ready), 64'(1));
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;

        // Single frame: bit stream, strobe timing and reconstructed word.
        tw = 32'hA5A5_0F0F;
        applyStimulus(1'b1, tw);
        in_valid = 1'b0;
        for (int k = 0; k < WIDTH; k++) begin
            @(posedge clk);
            #2;
            checkOutput("t1_bit", 64'(serial_out), 64'(tw[WIDTH-1-k]));
            checkOutput("t1_no_load", 64'(load_out), 64'(0));
        end
        @(posedge clk);
        #2;
        checkOutput("t1_load_high", 64'(load_out), 64'(1));
        checkOutput("t1_serial_low", 64'(serial_out), 64'(0));
        @(posedge clk);
        #2;
        checkOutput("t1_load_low", 64'(load_out), 64'(0));
        checkOutput("t1_words", 64'(words_sent), 64'(1));
        checkOutput("t1_wrap_words", 64'(words_sent1), 64'(1));
        checkOutput("t1_captures", 64'(captured.size()), 64'(1));
        checkOutput("t1_deser", 64'(captured[0]), 64'(32'hA5A5_0F0F));
        checkOutput("t1_idle_busy", 64'(busy), 64'(0));

        // Back-to-back burst with valid held high; the fourth word meets a full FIFO.
        burst[0] = 32'hFFFF_FFFF;
        burst[1] = 32'h0000_0001;
        burst[2] = 32'h8000_0000;
        burst[3] = 32'h5A5A_5A5A;
        for (int idx = 0; idx < 4; idx++) begin
            in_valid = 1'b1;
            in_data  = burst[idx];
            if (idx == 3) checkOutput("t2_full_ready", 64'(in_ready), 64'(0));
            stall  = 0;
            waited = 0;
            acc    = 1'b0;
            while (!acc && waited < 200) begin
                acc = in_ready;
                @(posedge clk);
                #2;
                if (!acc) stall++;
                waited++;
            end
            if (!acc) checkOutput("t2_push_timeout", 64'(0), 64'(1));
            if (idx == 3) checkOutput("t2_stalled", 64'(stall > 0), 64'(1));
        end
        idleCycles(4 * (WIDTH + 1) + 5);
        checkOutput("t2_words", 64'(words_sent), 64'(5));
        checkOutput("t2_captures", 64'(captured.size()), 64'(5));
        if (captured.size() == 5) begin
            for (int i = 0; i < 4; i++) checkOutput("t2_deser_order", 64'(captured[i+1]), 64'(burst[i]));
            for (int i = 1; i < 4; i++) checkOutput("t2_frame_spacing", 64'(loadCycles[i+1] - loadCycles[i]), 64'(33));
        end

        // Reset in the middle of a frame abandons it without a load pulse.
        applyStimulus(1'b1, 32'hDEAD_BEEF);
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        capBefore = captured.size();
        reset = 1'b0;
        #1;
        checkOutput("t3_async_serial", 64'(serial_out), 64'(0));
        checkOutput("t3_async_busy", 64'(busy), 64'(0));
        checkOutput("t3_async_words", 64'(words_sent), 64'(0));
        checkOutput("t3_async_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #2 reset = 1'b1;
        applyStimulus(1'b1, 32'h1234_5678);
        idleCycles(WIDTH + 6);
        checkOutput("t3_captures", 64'(captured.size()), 64'(capBefore + 1));
        checkOutput("t3_deser", 64'(captured[$]), 64'(32'h1234_5678));
        checkOutput("t3_words", 64'(words_sent), 64'(1));

        // Second frame after reset wraps the 1-bit counter back to zero.
        applyStimulus(1'b1, 32'hCAFE_F00D);
        idleCycles(WIDTH + 6);
        checkOutput("t5_wrap_words", 64'(words_sent1), 64'(0));
        checkOutput("t5_words", 64'(words_sent), 64'(2));
        checkOutput("t5_deser", 64'(captured[$]), 64'(32'hCAFE_F00D));

        // Noise on in_data with valid low must not start anything.
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b0;
            in_data  = $urandom;
            @(posedge clk);
            #2;
            checkOutput("t6_busy", 64'(busy), 64'(0));
            checkOutput("t6_load", 64'(load_out), 64'(0));
        end
        checkOutput("t6_words", 64'(words_sent), 64'(2));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
